// File: rtl/caf_framer_pkg.sv
// Shared definitions for the CAF capture framer: FSM states and the tdata field layout.
// The CAF core unpacks tdata with these same offsets.
package caf_framer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int TDATA_W = 32;
  localparam int XQ_LSB  = 0;

  // xi sits directly above xq in tdata
  function automatic int xi_lsb(input int q_bits);
    return XQ_LSB + q_bits;
  endfunction

endpackage

// File: rtl/caf_sample_fifo.sv
// Elastic sample FIFO. The head entry is presented through a registered read port,
// and it stays counted as occupancy until it is popped.
module caf_sample_fifo #(
  parameter int W  = 24,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic         rd_valid,
  output logic [W-1:0] rd_data
);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [AW:0]  rptr_nxt;

  assign rptr_nxt = rptr + (AW + 1)'(pop);
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  // Head is chosen from entries already in memory, so a fresh push reaches rd_data one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) wptr <= wptr + (AW + 1)'(1);
      rptr     <= rptr_nxt;
      rd_valid <= (wptr != rptr_nxt);
      if (wptr != rptr_nxt) rd_data <= mem[rptr_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/caf_capture_framer.sv
// Frames exactly CAP_LEN I/Q samples per start request into a 32-bit AXI-stream,
// absorbing backpressure in an elastic FIFO and counting dropped samples.
module caf_capture_framer
  import caf_framer_pkg::*;
#(
  parameter int I_BITS   = 12,
  parameter int Q_BITS   = 12,
  parameter int CAP_LEN  = 1024,
  parameter int CNT_BITS = 11,
  parameter int FIFO_AW  = 4,
  parameter int OVF_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sample_valid,
  input  logic [I_BITS-1:0]   xi,
  input  logic [Q_BITS-1:0]   xq,
  output logic [TDATA_W-1:0]  s_axis_tdata,
  output logic                s_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                busy,
  output logic                frame_done,
  output logic [OVF_BITS-1:0] ovf_count
);
  localparam int SAMPLE_W = I_BITS + Q_BITS;
  localparam int XI_LSB   = xi_lsb(Q_BITS);
  localparam logic [CNT_BITS-1:0] CAP_CNT  = CNT_BITS'(CAP_LEN);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(CAP_LEN - 1);

  state_t                state;
  logic [CNT_BITS-1:0]   in_cnt;
  logic [CNT_BITS-1:0]   out_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  rd_valid;
  logic [SAMPLE_W-1:0]   rd_data;
  logic                  accept_in;
  logic                  push;
  logic                  pop;

  // A pop on the same edge frees a slot, so a full FIFO still accepts the sample
  assign accept_in = (state == COLLECT) && sample_valid && (in_cnt != CAP_CNT);
  assign pop       = rd_valid && m_axis_tready;
  assign push      = accept_in && (!fifo_full || pop);

  caf_sample_fifo #(
    .W  (SAMPLE_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .din      ({xi, xq}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  always_comb begin
    s_axis_tdata = '0;
    s_axis_tdata[XQ_LSB +: Q_BITS] = rd_data[Q_BITS-1:0];
    s_axis_tdata[XI_LSB +: I_BITS] = rd_data[SAMPLE_W-1:Q_BITS];
  end

  assign s_axis_tvalid = rd_valid;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      ovf_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (pop) out_cnt <= out_cnt + CNT_BITS'(1);
      case (state)
        IDLE: begin
          if (start) begin
            in_cnt    <= '0;
            out_cnt   <= '0;
            ovf_count <= '0;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (push) begin
            in_cnt <= in_cnt + CNT_BITS'(1);
          end else if (accept_in && ovf_count != '1) begin
            ovf_count <= ovf_count + OVF_BITS'(1);
          end
          if (in_cnt == CAP_CNT) state <= DRAIN;
        end
        DRAIN: begin
          // Leave on the edge that transfers the final beat so frame_done follows it directly
          if (pop && out_cnt == LAST_CNT && !(fifo_empty && rd_valid)) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_caf_capture_framer.sv
// Self-checking bench for caf_capture_framer (CAP_LEN=8, FIFO depth 4) using a queue-based frame model.
module tb_caf_capture_framer;
  localparam int CAP   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sample_valid = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic [11:0] xi = '0;
  logic [11:0] xq = '0;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        busy;
  logic        frame_done;
  logic [15:0] ovf_count;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_beats;
  int          n_done;
  string       cur_test = "none";

  // Model: samples accepted but not yet transferred, in order
  logic [31:0] q[$];
  int          phase;  // 0 idle, 1 framing, 2 done pulse
  int          m_acc;
  int          m_sent;
  logic [15:0] m_ovf;
  logic        exp_tvalid;
  logic        hold_prev;
  logic [31:0] hold_data;

  always #5 clk = ~clk;

  caf_capture_framer #(
    .I_BITS(12), .Q_BITS(12), .CAP_LEN(CAP), .CNT_BITS(11), .FIFO_AW(2), .OVF_BITS(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .sample_valid  (sample_valid),
    .xi            (xi),
    .xq            (xq),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .frame_done    (frame_done),
    .ovf_count     (ovf_count)
  );

  task automatic model_reset();
    q.delete();
    phase = 0; m_acc = 0; m_sent = 0; m_ovf = '0;
    exp_tvalid = 1'b0; hold_prev = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model
  task automatic step(input logic sv, input logic [11:0] vi, input logic [11:0] vq,
                      input logic rdy, input logic st);
    logic        xfer;
    logic [31:0] exp_d;
    sample_valid = sv; xi = vi; xq = vq; m_axis_tready = rdy; start = st;
    @(negedge clk);
    n_vec++;
    if (s_axis_tvalid !== exp_tvalid) begin
      n_err++; $display("FAIL %s tvalid: got %b want %b", cur_test, s_axis_tvalid, exp_tvalid);
    end
    n_vec++;
    if (busy !== (phase != 0)) begin
      n_err++; $display("FAIL %s busy: got %b want %b", cur_test, busy, phase != 0);
    end
    n_vec++;
    if (frame_done !== (phase == 2)) begin
      n_err++; $display("FAIL %s frame_done: got %b want %b", cur_test, frame_done, phase == 2);
    end
    n_vec++;
    if (ovf_count !== m_ovf) begin
      n_err++; $display("FAIL %s ovf_count: got %0d want %0d", cur_test, ovf_count, m_ovf);
    end
    if (hold_prev) begin
      n_vec++;
      if (s_axis_tdata !== hold_data) begin
        n_err++; $display("FAIL %s stall tdata: got %h want %h", cur_test, s_axis_tdata, hold_data);
      end
    end
    xfer = (s_axis_tvalid === 1'b1) && rdy;
    if (xfer) begin
      n_beats++; m_sent++; n_vec++;
      if (q.size() == 0) begin
        n_err++; $display("FAIL %s beat: got %h want no beat", cur_test, s_axis_tdata);
      end else begin
        exp_d = q.pop_front();
        if (s_axis_tdata !== exp_d) begin
          n_err++; $display("FAIL %s beat data: got %h want %h", cur_test, s_axis_tdata, exp_d);
        end
      end
    end
    if (frame_done === 1'b1) n_done++;
    hold_prev = (s_axis_tvalid === 1'b1) && !rdy;
    hold_data = s_axis_tdata;
    // A sample accepted now becomes visible only after the next edge
    exp_tvalid = (q.size() != 0);
    case (phase)
      0: if (st) begin phase = 1; m_acc = 0; m_sent = 0; m_ovf = '0; end
      1: begin
        if (sv && m_acc < CAP) begin
          if (q.size() < DEPTH) begin
            q.push_back({8'h00, vi, vq}); m_acc++;
          end else if (m_ovf != 16'hFFFF) begin
            m_ovf++;
          end
        end
        if (m_sent == CAP) phase = 2;
      end
      default: phase = 0;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic run_to_idle(input int budget);
    int c = 0;
    while (phase != 0 && c < budget) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      c++;
    end
    n_vec++;
    if (phase != 0) begin
      n_err++; $display("FAIL %s timeout: still framing after %0d cycles, want idle", cur_test, budget);
    end
  endtask

  task automatic test_reset(input string tag);
    cur_test = tag;
    rst_n = 1'b0;
    sample_valid = 1'b0; start = 1'b0; m_axis_tready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (s_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL %s tvalid: got %b want 0", tag, s_axis_tvalid); end
    n_vec++; if (s_axis_tdata !== 32'h0) begin n_err++; $display("FAIL %s tdata: got %h want 0", tag, s_axis_tdata); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s busy: got %b want 0", tag, busy); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL %s frame_done: got %b want 0", tag, frame_done); end
    n_vec++; if (ovf_count !== 16'h0) begin n_err++; $display("FAIL %s ovf_count: got %0d want 0", tag, ovf_count); end
    rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_basic(input string tag);
    cur_test = tag; n_beats = 0; n_done = 0;
    step(1'b0, '0, '0, 1'b1, 1'b1);
    for (int k = 1; k <= CAP; k++) step(1'b1, 12'(k), 12'(-k), 1'b1, 1'b0);
    run_to_idle(30);
    n_vec++; if (n_beats != CAP) begin n_err++; $display("FAIL %s beats: got %0d want %0d", tag, n_beats, CAP); end
    n_vec++; if (n_done != 1) begin n_err++; $display("FAIL %s done pulses: got %0d want 1", tag, n_done); end
    n_vec++; if (ovf_count !== 16'h0) begin n_err++; $display("FAIL %s ovf_count: got %0d want 0", tag, ovf_count); end
  endtask

  task automatic test_backpressure();
    cur_test = "backpressure"; n_beats = 0; n_done = 0;
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step(k < 8, 12'(k + 16), 12'(k + 32), 1'b0, 1'b0);
    n_vec++; if (ovf_count !== 16'd4) begin n_err++; $display("FAIL backpressure ovf_count: got %0d want 4", ovf_count); end
    for (int k = 0; k < 10; k++) step(1'b0, '0, '0, 1'b1, 1'b0);
    n_vec++; if (n_beats != 4) begin n_err++; $display("FAIL backpressure beats: got %0d want 4", n_beats); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL backpressure busy: got %b want 1", busy); end
    n_vec++; if (n_done != 0) begin n_err++; $display("FAIL backpressure done pulses: got %0d want 0", n_done); end
    test_reset("backpressure_reset");
  endtask

  task automatic test_full_simul();
    cur_test = "full_simul"; n_beats = 0; n_done = 0;
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 1; k <= DEPTH; k++) step(1'b1, 12'(k * 3), 12'(k * 5), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    for (int k = DEPTH + 1; k <= CAP; k++) begin
      step(1'b1, 12'(k * 3), 12'(k * 5), 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b0, 1'b0);
    end
    run_to_idle(30);
    n_vec++; if (ovf_count !== 16'h0) begin n_err++; $display("FAIL full_simul ovf_count: got %0d want 0", ovf_count); end
    n_vec++; if (n_beats != CAP) begin n_err++; $display("FAIL full_simul beats: got %0d want %0d", n_beats, CAP); end
    n_vec++; if (n_done != 1) begin n_err++; $display("FAIL full_simul done pulses: got %0d want 1", n_done); end
  endtask

  task automatic test_start_busy();
    cur_test = "start_busy"; n_beats = 0; n_done = 0;
    step(1'b0, '0, '0, 1'b1, 1'b1);
    for (int k = 1; k <= CAP; k++) step(1'b1, 12'(k + 100), 12'(k + 200), 1'b1, k == 4);
    run_to_idle(30);
    for (int k = 0; k < 3; k++) step(1'b1, 12'hABC, 12'h123, 1'b1, 1'b0);
    n_vec++; if (n_beats != CAP) begin n_err++; $display("FAIL start_busy beats: got %0d want %0d", n_beats, CAP); end
    n_vec++; if (n_done != 1) begin n_err++; $display("FAIL start_busy done pulses: got %0d want 1", n_done); end
  endtask

  task automatic test_mid_reset();
    int c = 0;
    cur_test = "mid_reset"; n_beats = 0; n_done = 0;
    step(1'b0, '0, '0, 1'b1, 1'b1);
    while (n_beats < 3 && c < 20) begin
      step(1'b1, 12'(c + 7), 12'(c + 9), 1'b1, 1'b0);
      c++;
    end
    n_vec++; if (n_beats != 3) begin n_err++; $display("FAIL mid_reset beats before reset: got %0d want 3", n_beats); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (s_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_reset tvalid: got %b want 0", s_axis_tvalid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_reset busy: got %b want 0", busy); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 12'h555, 12'h666, 1'b1, 1'b0);
    n_vec++; if (n_done != 0) begin n_err++; $display("FAIL mid_reset done pulses: got %0d want 0", n_done); end
    test_basic("mid_reset_refill");
  endtask

  task automatic test_excess();
    cur_test = "excess"; n_beats = 0; n_done = 0;
    step(1'b0, '0, '0, 1'b1, 1'b1);
    for (int k = 1; k <= 12; k++) step(1'b1, 12'(k + 40), 12'(k + 80), 1'b1, 1'b0);
    run_to_idle(30);
    n_vec++; if (n_beats != CAP) begin n_err++; $display("FAIL excess beats: got %0d want %0d", n_beats, CAP); end
    n_vec++; if (ovf_count !== 16'h0) begin n_err++; $display("FAIL excess ovf_count: got %0d want 0", ovf_count); end
    n_vec++; if (n_done != 1) begin n_err++; $display("FAIL excess done pulses: got %0d want 1", n_done); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int c = 0;
      cur_test = "random"; n_beats = 0; n_done = 0;
      step(1'b0, '0, '0, 1'b1, 1'b1);
      while (phase != 0 && c < 400) begin
        step($urandom_range(0, 1) == 1, 12'($urandom), 12'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        c++;
      end
      n_vec++; if (n_beats != CAP) begin n_err++; $display("FAIL random frame %0d beats: got %0d want %0d", f, n_beats, CAP); end
      n_vec++; if (n_done != 1) begin n_err++; $display("FAIL random frame %0d done pulses: got %0d want 1", f, n_done); end
    end
  endtask

  initial begin
    model_reset();
    test_reset("reset");
    test_basic("basic");
    test_backpressure();
    test_full_simul();
    test_start_busy();
    test_mid_reset();
    test_excess();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
